// File: rtl/data_process_controller_if.sv
// Bundle of datapath-facing signals for the data-processing instruction controller.
// The controller takes the slave side; whoever drives the instruction/ALU side takes the master side.
interface data_process_controller_if;
  logic        start;
  logic [31:0] inst;
  logic [31:0] pc_data;
  logic        alu_zero;
  logic        alu_neg;
  logic        alu_ovf;
  logic        shft_carry;
  logic        rd_pc;
  logic        rd_inst;
  logic        rd_1;
  logic        rd_2;
  logic        rd_3;
  logic        shft_en;
  logic        alu_en;
  logic        wr_reg_file;
  logic        wr_pc;
  logic [31:0] pc_next;
  logic        carry_flag;
  logic [3:0]  flags;
  logic        busy;
  logic        done;

  modport master (
    output start, inst, pc_data, alu_zero, alu_neg, alu_ovf, shft_carry,
    input  rd_pc, rd_inst, rd_1, rd_2, rd_3, shft_en, alu_en, wr_reg_file, wr_pc,
    input  pc_next, carry_flag, flags, busy, done
  );

  modport slave (
    input  start, inst, pc_data, alu_zero, alu_neg, alu_ovf, shft_carry,
    output rd_pc, rd_inst, rd_1, rd_2, rd_3, shft_en, alu_en, wr_reg_file, wr_pc,
    output pc_next, carry_flag, flags, busy, done
  );
endinterface

// File: rtl/data_process_controller.sv
// Six-cycle sequencer for one ARM-style data-processing instruction, with flag latching.
// Define COND_EXEC_EN to evaluate the cond field against the latched flags; otherwise every instruction executes.
module data_process_controller (
  input logic                      clk,
  input logic                      rst,
  data_process_controller_if.slave bus
);

  typedef enum logic [6:0] {
    IDLE       = 7'b0000001,
    FETCH_PC   = 7'b0000010,
    FETCH_INST = 7'b0000100,
    READ       = 7'b0001000,
    SHIFT      = 7'b0010000,
    EXEC       = 7'b0100000,
    WB         = 7'b1000000
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [3:0]  flags_q, flags_d;
  logic        cond_ok_q, cond_ok_d;
  logic        cond_pass;

  logic rd_pc, rd_inst, rd_1, rd_2, rd_3, shft_en, alu_en, wr_reg_file, wr_pc, done;

`ifdef COND_EXEC_EN
  logic nf, zf, cf, vf;
  assign {nf, zf, cf, vf} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (inst_q[31:28])
      4'h0: cond_pass = zf;
      4'h1: cond_pass = !zf;
      4'h2: cond_pass = cf;
      4'h3: cond_pass = !cf;
      4'h4: cond_pass = nf;
      4'h5: cond_pass = !nf;
      4'h6: cond_pass = vf;
      4'h7: cond_pass = !vf;
      4'h8: cond_pass = cf && !zf;
      4'h9: cond_pass = !cf || zf;
      4'hA: cond_pass = (nf == vf);
      4'hB: cond_pass = (nf != vf);
      4'hC: cond_pass = !zf && (nf == vf);
      4'hD: cond_pass = zf || (nf != vf);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  logic unused_inst;
  assign unused_inst = ^{inst_q[27:26], inst_q[22:21], inst_q[19:5], inst_q[3:0]};
`else
  assign cond_pass = 1'b1;

  logic unused_inst;
  assign unused_inst = ^{inst_q[31:28], inst_q[27:26], inst_q[22:21], inst_q[19:5], inst_q[3:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      pc_next_q <= '0;
      flags_q   <= '0;
      cond_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      pc_next_q <= pc_next_d;
      flags_q   <= flags_d;
      cond_ok_q <= cond_ok_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    inst_d      = inst_q;
    pc_next_d   = pc_next_q;
    flags_d     = flags_q;
    cond_ok_d   = cond_ok_q;
    rd_pc       = 1'b0;
    rd_inst     = 1'b0;
    rd_1        = 1'b0;
    rd_2        = 1'b0;
    rd_3        = 1'b0;
    shft_en     = 1'b0;
    alu_en      = 1'b0;
    wr_reg_file = 1'b0;
    wr_pc       = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = FETCH_PC;
      FETCH_PC: begin
        rd_pc     = 1'b1;
        pc_next_d = bus.pc_data + 32'd4;
        state_d   = FETCH_INST;
      end
      FETCH_INST: begin
        rd_inst = 1'b1;
        inst_d  = bus.inst;
        state_d = READ;
      end
      READ: begin
        rd_1    = 1'b1;
        rd_2    = 1'b1;
        rd_3    = !inst_q[25] && inst_q[4];
        state_d = SHIFT;
      end
      SHIFT: begin
        shft_en = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        alu_en = 1'b1;
        // Condition is judged on the pre-update flags and carried into WB.
        cond_ok_d = cond_pass;
        if (inst_q[20] && cond_pass)
          flags_d = {bus.alu_neg, bus.alu_zero, bus.shft_carry, bus.alu_ovf};
        state_d = WB;
      end
      WB: begin
        wr_pc       = 1'b1;
        done        = 1'b1;
        // TST/TEQ/CMP/CMN (opcode 10xx) only set flags.
        wr_reg_file = cond_ok_q && (inst_q[24:23] != 2'b10);
        state_d     = bus.start ? FETCH_PC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rd_pc       = rd_pc;
  assign bus.rd_inst     = rd_inst;
  assign bus.rd_1        = rd_1;
  assign bus.rd_2        = rd_2;
  assign bus.rd_3        = rd_3;
  assign bus.shft_en     = shft_en;
  assign bus.alu_en      = alu_en;
  assign bus.wr_reg_file = wr_reg_file;
  assign bus.wr_pc       = wr_pc;
  assign bus.done        = done;
  assign bus.busy        = (state_q != IDLE);
  assign bus.pc_next     = pc_next_q;
  assign bus.flags       = flags_q;
  assign bus.carry_flag  = flags_q[1];

endmodule

// File: tb/tb_data_process_controller.sv
// Scoreboarded bench: the driver pushes the expected per-cycle view of the controller,
// a negedge monitor pops and compares it against the DUT.
module tb_data_process_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_process_controller_if bus ();
  data_process_controller dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [10:0] strb;
    logic [31:0] pc;
    logic [3:0]  fl;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_pc;
  logic [3:0]  m_flags;

  // {busy, done, rd_pc, rd_inst, rd_1, rd_2, rd_3, shft_en, alu_en, wr_reg_file, wr_pc}
  function automatic logic [10:0] mk(bit busy, bit dn, bit rpc, bit rinst, bit r12, bit r3,
                                     bit sh, bit alu, bit wrf, bit wpc);
    return {busy, dn, rpc, rinst, r12, r12, r3, sh, alu, wrf, wpc};
  endfunction

  // ARM condition codes: even code tests a predicate, odd code is its inverse (AL/NV pair included).
  function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
`ifdef COND_EXEC_EN
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return r ^ cc[0];
`else
    return (cc == f) || 1'b1;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [10:0] s);
    exp_t e;
    e.strb = s;
    e.pc   = m_pc;
    e.fl   = m_flags;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [10:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {bus.busy, bus.done, bus.rd_pc, bus.rd_inst, bus.rd_1, bus.rd_2, bus.rd_3,
             bus.shft_en, bus.alu_en, bus.wr_reg_file, bus.wr_pc};
      chk("strobes", {21'd0, act}, {21'd0, e.strb});
      chk("pc_next", bus.pc_next, e.pc);
      chk("flags", {28'd0, bus.flags}, {28'd0, e.fl});
      chk("carry_flag", {31'd0, bus.carry_flag}, {31'd0, e.fl[1]});
    end
  end

  task automatic rand_alu();
    logic [31:0] r;
    r = $urandom;
    {bus.alu_neg, bus.alu_zero, bus.shft_carry, bus.alu_ovf} = r[3:0];
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  // Entered at posedge+1 while the DUT sits in IDLE or WB; returns at posedge+1 in WB
  // (or in IDLE after a reset injected during EXEC when abort is set).
  task automatic run(input logic [31:0] ins, input logic [31:0] pc, input logic [3:0] nzcv,
                     input bit abort);
    bit pass, wrf;
    bus.start   = 1'b1;
    bus.pc_data = pc;
    bus.inst    = $urandom;
    rand_alu();
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      case (k)
        1: push(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        2: begin
          m_pc = pc + 32'd4;
          push(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
          bus.inst    = ins;
          bus.pc_data = $urandom;
        end
        3: begin
          push(mk(1, 0, 0, 0, 1, !ins[25] && ins[4], 0, 0, 0, 0));
          bus.inst = $urandom;
        end
        4: push(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        5: begin
          push(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
          {bus.alu_neg, bus.alu_zero, bus.shft_carry, bus.alu_ovf} = nzcv;
          pass = cond_ok(ins[31:28], m_flags);
          if (abort) begin
            rst = 1'b1;
            @(posedge clk); #1;
            m_pc    = '0;
            m_flags = '0;
            push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            return;
          end
        end
        default: begin
          if (ins[20] && pass) m_flags = nzcv;
          wrf = pass && !(ins[24:21] >= 4'd8 && ins[24:21] <= 4'd11);
          push(mk(1, 1, 0, 0, 0, 0, 0, 0, wrf, 1));
          rand_alu();
        end
      endcase
      if (k < 6) bus.start = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.inst    = '0;
    bus.pc_data = '0;
    {bus.alu_neg, bus.alu_zero, bus.shft_carry, bus.alu_ovf} = 4'd0;
    m_pc    = '0;
    m_flags = '0;
    @(posedge clk); #1;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.start = 1'b1;  // reset must win over start
    @(posedge clk); #1;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    idle(2);

    run(32'hE0812003, 32'h0000_0000, 4'b0000, 0); idle(2);  // ADD
    run(32'hE1510002, 32'h0000_0100, 4'b0100, 0); idle(1);  // CMPS, Z=1
    run(32'hE0912003, 32'h0000_0200, 4'b0000, 0); idle(1);  // ADDS clears flags
    run(32'h00812003, 32'h0000_0300, 4'b1111, 0); idle(1);  // ADDEQ with Z=0
    run(32'hE0812314, 32'h0000_0400, 4'b0000, 0); idle(1);  // register shift
    run(32'hE0912003, 32'hFFFF_FFF8, 4'b1010, 0);           // back-to-back, PC wrap
    run(32'hE0812003, 32'hFFFF_FFFC, 4'b0000, 0); idle(1);

    for (int i = 0; i < 30; i++) begin
      run($urandom, $urandom, 4'($urandom_range(0, 15)), 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);

    run(32'hE0912003, 32'h0000_0500, 4'b1111, 1);           // reset during EXEC
    bus.start = 1'b1;
    @(posedge clk); #1;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    idle(1);
    run(32'hE0912003, 32'h0000_0600, 4'b1010, 0); idle(3);

    @(posedge clk); #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/data_process_controller.md
DATA_PROCESS_CONTROLLER -- requirements
Module: data_process_controller

Interface
REQ-001 The block SHALL have the following ports, each with direction, width and meaning:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to run one data-processing instruction.
- inst  input  32  instruction-memory output; used fields are cond[31:28], I[25], opcode[24:21], S[20], shift-by-register[4].
- pc_data  input  32  current PC value from the register file.
- alu_zero, alu_neg, alu_ovf  input  1 each  ALU flag outputs.
- shft_carry  input  1  shifter carry_out_flag.
- rd_pc, rd_inst, rd_1, rd_2, rd_3, shft_en, alu_en, wr_reg_file, wr_pc  output  1 each  datapath strobes.
- pc_next  output  32  next PC value presented to the register file.
- carry_flag  output  1  latched C flag, fed to the shifter and ALU.
- flags  output  4  latched {N,Z,C,V}.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-002 The FSM SHALL have the states IDLE, FETCH_PC, FETCH_INST, READ, SHIFT, EXEC and WB, with one-hot state encoding.
REQ-003 In IDLE with start=1, the FSM SHALL go to FETCH_PC; otherwise it SHALL remain in IDLE.
REQ-004 States SHALL advance unconditionally in this order: FETCH_PC, FETCH_INST, READ, SHIFT, EXEC, WB, giving 6 cycles per instruction.
REQ-005 At WB, the FSM SHALL go to FETCH_PC if start=1, else to IDLE, so back-to-back instructions incur no idle cycle.
REQ-006 Strobes SHALL be Moore outputs of the state, each asserted only in its listed state:
- rd_pc in FETCH_PC.
- rd_inst in FETCH_INST.
- rd_1 and rd_2 in READ.
- rd_3 in READ only when I=0 and inst[4]=1.
- shft_en in SHIFT.
- alu_en in EXEC.
- wr_reg_file and wr_pc in WB, subject to REQ-008 and REQ-009.
REQ-007 The block SHALL register inst into an internal 32-bit register at the FETCH_INST-to-READ edge; all decode SHALL use this registered copy.
REQ-008 wr_reg_file SHALL be suppressed for opcodes 1000..1011 (TST, TEQ, CMP, CMN) and when the condition check fails.
REQ-009 wr_pc SHALL be asserted in every WB, including failed-condition instructions.
REQ-010 pc_next SHALL equal the pc_data registered in FETCH_PC plus 4, modulo 2^32; 0xFFFFFFFC SHALL wrap to 0x00000000.
REQ-011 On the EXEC-to-WB edge, if S=1 and the condition passes, flags SHALL capture N=alu_neg, Z=alu_zero, C=shft_carry and V=alu_ovf; otherwise flags SHALL hold.
REQ-012 carry_flag SHALL always equal flags C.
REQ-013 done SHALL be high exactly in WB; busy SHALL be low only in IDLE.
REQ-014 start SHALL be ignored in all states except IDLE and WB.

Reset
REQ-015 When rst=1 at a clock edge, the FSM SHALL enter IDLE from any state, including mid-instruction.
REQ-016 During reset, all strobes, busy, done, flags, carry_flag and the instruction register SHALL be 0, and pc_next SHALL be 0x00000000.
REQ-017 rst SHALL take priority over start on the same edge.

Configuration
REQ-018 With macro COND_EXEC_EN defined, the condition check SHALL evaluate cond against the latched flags using the 16 ARM codes (EQ..AL, with NV treated as never).
REQ-019 Without COND_EXEC_EN, the condition check SHALL always pass and cond SHALL be ignored.

Verification
REQ-020 Reset, then start=1 for one cycle with inst=0xE0812003 (ADD) and pc_data=0x00000000: strobes SHALL follow REQ-006 over 6 cycles, wr_reg_file=1, pc_next=0x00000004, done pulses in cycle 6.
REQ-021 inst=0xE1510002 (CMPS) with alu_zero=1 in EXEC: wr_reg_file SHALL be 0, wr_pc SHALL be 1, flags SHALL become 4'b0100 when shft_carry=0.
REQ-022 With COND_EXEC_EN defined, Z=0 and inst=0x00812003 (ADDEQ): wr_reg_file SHALL be 0, wr_pc SHALL be 1, flags SHALL be unchanged; without the macro, wr_reg_file SHALL be 1.
REQ-023 inst=0xE0812314 (register shift): rd_3 SHALL be 1 in READ; for inst=0xE0812003, rd_3 SHALL stay 0.
REQ-024 Hold start=1 across two instructions: WB of the first SHALL be followed directly by FETCH_PC; pc_data=0xFFFFFFFC SHALL give pc_next=0x00000000.
REQ-025 Assert rst during EXEC: the next cycle SHALL be IDLE with all outputs 0, and no WB strobe SHALL occur.
